bus_uart_tx: RTL and testbench

- Bus-side sink peripheral: captures a byte from the 8-bit CPU data bus on a write strobe, buffers it in a small FIFO and serialises it as a UART frame on o_tx.
- Counterpart to the bus-driving register/transceiver blocks: consumes bus data instead of sourcing it.
- Gives the CPU a character output port with flow-control status.

---
 rtl/bus_uart_tx_if.sv | 22 ++
 rtl/bus_uart_tx.sv | 219 +++++++++++++++++++++
 tb/tb_bus_uart_tx.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_uart_tx_if.sv
// Bus-side connection of the UART transmit peripheral: the CPU write strobe,
// data byte and error-clear, plus FIFO/transmitter status and the serial line.
interface bus_uart_tx_if;
  logic [7:0] i_bus;
  logic       i_write;
  logic       i_clearErr;
  logic       o_full;
  logic       o_empty;
  logic       o_txBusy;
  logic       o_overflow;
  logic       o_tx;

  modport master (
    output i_bus, i_write, i_clearErr,
    input  o_full, o_empty, o_txBusy, o_overflow, o_tx
  );

  modport slave (
    input  i_bus, i_write, i_clearErr,
    output o_full, o_empty, o_txBusy, o_overflow, o_tx
  );
endinterface

// File: rtl/bus_uart_tx.sv
// bus_uart_tx: captures bytes written from the CPU bus into a small FIFO and
// serialises them as 8N1 UART frames (LSB first) on o_tx.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (11 bit times per frame).
module bus_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  bus_uart_tx_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif

  // FIFO storage and control
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic             push, drop, pop;
  logic [7:0]       head;

  // Transmitter state
  state_e           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             baud_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // A write only lands when the FIFO was not full before this edge; a pop in
  // the same cycle never frees room for it.
  assign push = bus.i_write & ~full_q;
  assign drop = bus.i_write & full_q;
  assign head = mem_q[rd_ptr_q];

  // FIFO pointer, occupancy, flag and sticky-overflow next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);
    ovf_d   = ovf_q;
    if (drop)                ovf_d = 1'b1;
    else if (bus.i_clearErr) ovf_d = 1'b0;
  end

  // FIFO control registers; flags are registered from the next count so they
  // are exact in the cycle after every push/pop
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO data array; contents need no reset since the pointers define validity
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.i_bus;
  end

  assign baud_end = (baud_q == BAUD_LAST);

  // Transmitter next state: bit timing, shifting and FIFO pops
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_q) begin
          pop     = 1'b1;
          state_d = START;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          state_d = STOP;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next frame when more data is waiting
          if (!empty_q) begin
            pop     = 1'b1;
            state_d = START;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) shift_d = head;
  end

`ifdef UART_TX_PARITY_EN
  // Even parity of the byte, captured at the moment it leaves the FIFO
  always_comb begin
    parity_d = parity_q;
    if (pop) parity_d = ^head;
  end
`endif

  // Line level for the state being entered, so o_tx is a plain register
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // Transmitter control registers; reset aborts any frame in progress
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  // Shift register (and parity) hold data only, loaded on every pop
  always_ff @(posedge i_clk) begin
    shift_q  <= shift_d;
`ifdef UART_TX_PARITY_EN
    parity_q <= parity_d;
`endif
  end

  assign bus.o_full     = full_q;
  assign bus.o_empty    = empty_q;
  assign bus.o_overflow = ovf_q;
  assign bus.o_txBusy   = (state_q != IDLE);
  assign bus.o_tx       = tx_q;

endmodule

// File: tb/tb_bus_uart_tx.sv
// Testbench for bus_uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Exercises fixed frame vectors, back-to-back, overflow, pointer wrap,
// mid-frame reset and a randomized run against a time-based model.
module tb_bus_uart_tx;
  localparam int C = 4;
  localparam int D = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam int NV = 4;
`else
  localparam int NB = 10;
  localparam int NV = 5;
`endif

  typedef struct {
    logic [7:0]    data;
    logic [NB-1:0] frame;   // bit 0 = start bit, sent first
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bus_uart_tx_if bus_if ();

  bus_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus_if.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model / scoreboard state
  bit          model_on = 1'b0;
  longint      cyc = 0;
  logic [7:0]  mq[$];
  logic [7:0]  sent_q[$];
  logic [7:0]  rx_q[$];
  bit          busy_m;
  bit          ovf_m;
  longint      end_edge;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Spec-level model: a byte leaves the FIFO when the line is idle or when the
  // previous frame's NB*C cycles are over; writes into a full FIFO are dropped.
  task automatic model_step(input logic w, input logic [7:0] d, input logic ce);
    int  pre;
    bit  full, popm;
    pre  = mq.size();
    full = (pre == D);
    popm = 1'b0;
    if (busy_m) begin
      if (cyc == end_edge) begin
        if (pre > 0) popm = 1'b1;
        else busy_m = 1'b0;
      end
    end else if (pre > 0) begin
      popm = 1'b1;
    end
    if (popm) begin
      sent_q.push_back(mq.pop_front());
      busy_m   = 1'b1;
      end_edge = cyc + NB * C;
    end
    if (w && !full) mq.push_back(d);
    if (w && full) ovf_m = 1'b1;
    else if (ce)   ovf_m = 1'b0;
  endtask

  task automatic tick();
    logic       w, ce;
    logic [7:0] d;
    w  = bus_if.i_write;
    d  = bus_if.i_bus;
    ce = bus_if.i_clearErr;
    @(posedge clk);
    cyc++;
    #1;
    if (model_on) begin
      model_step(w, d, ce);
      check("rnd_full",  bus_if.o_full,     (mq.size() == D));
      check("rnd_empty", bus_if.o_empty,    (mq.size() == 0));
      check("rnd_busy",  bus_if.o_txBusy,   busy_m);
      check("rnd_ovf",   bus_if.o_overflow, ovf_m);
    end
  endtask

  // Line monitor: finds a start bit and samples each bit in its middle
  initial begin
    int         mcnt;
    int         idx;
    bit         mact;
    logic [7:0] mbyte;
    mact = 1'b0;
    mcnt = 0;
    mbyte = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mact = 1'b0;
      end else if (!mact) begin
        if (bus_if.o_tx === 1'b0) begin
          mact = 1'b1;
          mcnt = 0;
        end
      end else begin
        mcnt++;
        if (mcnt % C == C / 2) begin
          idx = mcnt / C;
          if (idx == 0) begin
            check("mon_start", bus_if.o_tx, 1'b0);
          end else if (idx == NB - 1) begin
            check("mon_stop", bus_if.o_tx, 1'b1);
            rx_q.push_back(mbyte);
            mact = 1'b0;
          end else if (idx == 9) begin
            check("mon_parity", bus_if.o_tx, ^mbyte);
          end else begin
            mbyte[idx-1] = bus_if.o_tx;
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus_if.i_write = 1'b0;
    bus_if.i_clearErr = 1'b0;
    bus_if.i_bus = '0;
    tick();
    tick();
    rst = 1'b0;
    rx_q.delete();
  endtask

  task automatic write_byte(input logic [7:0] d);
    bus_if.i_bus = d;
    bus_if.i_write = 1'b1;
    tick();
    bus_if.i_write = 1'b0;
  endtask

  // Checks NB*C consecutive cycles of o_tx; pre=1 means the first cycle is
  // already current and is checked without advancing.
  task automatic expect_frame(input logic [NB-1:0] fr, input bit pre, input bit chk_empty,
                              input string name);
    int errs;
    errs = 0;
    for (int c = 1; c <= NB * C; c++) begin
      if (!(c == 1 && pre)) tick();
      if (bus_if.o_tx !== fr[(c-1)/C]) begin
        errs++;
        $display("FAIL %s_tx cycle %0d: got %b expected %b", name, c, bus_if.o_tx, fr[(c-1)/C]);
      end
      if (c == 1) check({name, "_busy"}, bus_if.o_txBusy, 1'b1);
      if (c == 2 && chk_empty) check({name, "_empty"}, bus_if.o_empty, 1'b1);
    end
    total++;
    if (errs != 0) bad++;
  endtask

  task automatic wait_rx(input int n, input int limit, input string name);
    int k;
    k = 0;
    while (rx_q.size() < n && k < limit) begin
      tick();
      k++;
    end
    check({name, "_timeout"}, (rx_q.size() >= n), 1'b1);
  endtask

  vec_t vecs[NV];
  logic [NB-1:0] f00, fff;

  initial begin
    bus_if.i_write = 1'b0;
    bus_if.i_clearErr = 1'b0;
    bus_if.i_bus = '0;

`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'hA5, 11'b1_0_10100101_0};
    vecs[1] = '{8'h07, 11'b1_1_00000111_0};
    vecs[2] = '{8'h03, 11'b1_0_00000011_0};
    vecs[3] = '{8'h80, 11'b1_1_10000000_0};
    f00 = 11'b1_0_00000000_0;
    fff = 11'b1_0_11111111_0;
`else
    vecs[0] = '{8'hA5, 10'b1_10100101_0};
    vecs[1] = '{8'h00, 10'b1_00000000_0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0};
    vecs[3] = '{8'h80, 10'b1_10000000_0};
    vecs[4] = '{8'h3C, 10'b1_00111100_0};
    f00 = 10'b1_00000000_0;
    fff = 10'b1_11111111_0;
`endif

    // Reset state
    do_reset();
    check("rst_tx",    bus_if.o_tx,       1'b1);
    check("rst_empty", bus_if.o_empty,    1'b1);
    check("rst_full",  bus_if.o_full,     1'b0);
    check("rst_busy",  bus_if.o_txBusy,   1'b0);
    check("rst_ovf",   bus_if.o_overflow, 1'b0);

    // Single-frame vectors
    for (int v = 0; v < NV; v++) begin
      do_reset();
      write_byte(vecs[v].data);
      check("vec_empty_after_write", bus_if.o_empty, 1'b0);
      expect_frame(vecs[v].frame, 1'b0, 1'b1, "vec");
      tick();
      check("vec_busy_end", bus_if.o_txBusy, 1'b0);
      check("vec_tx_end",   bus_if.o_tx,     1'b1);
      check("vec_rx_count", rx_q.size(), 1);
      if (rx_q.size() > 0) check("vec_rx_byte", rx_q[0], vecs[v].data);
    end

    // Back-to-back frames: no idle cycle between them
    do_reset();
    write_byte(8'h00);
    bus_if.i_bus = 8'hFF;
    bus_if.i_write = 1'b1;
    tick();
    bus_if.i_write = 1'b0;
    expect_frame(f00, 1'b1, 1'b0, "b2b_first");
    expect_frame(fff, 1'b0, 1'b1, "b2b_second");
    tick();
    check("b2b_busy_end", bus_if.o_txBusy, 1'b0);
    check("b2b_rx_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("b2b_rx0", rx_q[0], 8'h00);
      check("b2b_rx1", rx_q[1], 8'hFF);
    end

    // Overflow: six writes in a row while idle
    do_reset();
    for (int i = 1; i <= 6; i++) write_byte(8'h50 + 8'(i));
    check("ovf_full",  bus_if.o_full,     1'b1);
    check("ovf_flag",  bus_if.o_overflow, 1'b1);
    check("ovf_empty", bus_if.o_empty,    1'b0);
    bus_if.i_clearErr = 1'b1;
    tick();
    bus_if.i_clearErr = 1'b0;
    check("ovf_cleared", bus_if.o_overflow, 1'b0);
    check("ovf_still_full", bus_if.o_full, 1'b1);
    wait_rx(5, 6 * NB * C, "ovf");
    for (int i = 0; i < 2 * NB * C; i++) tick();
    check("ovf_rx_count", rx_q.size(), 5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++) check("ovf_rx_byte", rx_q[i], 8'h51 + 8'(i));
    check("ovf_drained", bus_if.o_empty, 1'b1);

    // Pointer wrap: twelve bytes, each written only while not full
    do_reset();
    for (int v = 1; v <= 12; v++) begin
      int k;
      k = 0;
      while (bus_if.o_full === 1'b1 && k < 4 * NB * C) begin
        tick();
        k++;
      end
      if (bus_if.o_full !== 1'b0) check("wrap_full_timeout", bus_if.o_full, 1'b0);
      write_byte(8'(v));
    end
    wait_rx(12, 14 * NB * C, "wrap");
    check("wrap_rx_count", rx_q.size(), 12);
    for (int i = 0; i < 12 && i < rx_q.size(); i++) check("wrap_rx_byte", rx_q[i], 8'(i + 1));

    // Reset during DATA bit 3 of 0x3C with two bytes queued
    do_reset();
    write_byte(8'h3C);
    write_byte(8'h11);
    write_byte(8'h22);
    for (int i = 0; i < 15; i++) tick();
    check("mrst_bit3", bus_if.o_tx, 1'b1);
    check("mrst_queued", bus_if.o_empty, 1'b0);
    rst = 1'b1;
    tick();
    check("mrst_tx",    bus_if.o_tx,     1'b1);
    check("mrst_empty", bus_if.o_empty,  1'b1);
    check("mrst_busy",  bus_if.o_txBusy, 1'b0);
    check("mrst_full",  bus_if.o_full,   1'b0);
    rst = 1'b0;
    begin
      int lows;
      lows = 0;
      for (int i = 0; i < 3 * NB * C; i++) begin
        tick();
        if (bus_if.o_tx !== 1'b1) lows++;
      end
      check("mrst_line_idle", lows, 0);
      check("mrst_no_frames", rx_q.size(), 0);
    end

    // Randomized traffic against the model
    do_reset();
    mq.delete();
    sent_q.delete();
    busy_m = 1'b0;
    ovf_m  = 1'b0;
    model_on = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      bus_if.i_write    = ($urandom_range(0, 99) < 7);
      bus_if.i_bus      = 8'($urandom);
      bus_if.i_clearErr = ($urandom_range(0, 99) < 3);
      tick();
    end
    bus_if.i_write = 1'b0;
    bus_if.i_clearErr = 1'b0;
    for (int i = 0; i < 7 * NB * C; i++) tick();
    model_on = 1'b0;
    check("rnd_rx_count", rx_q.size(), sent_q.size());
    for (int i = 0; i < rx_q.size() && i < sent_q.size(); i++) check("rnd_rx_byte", rx_q[i], sent_q[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
